// File: rtl/bcd_min_sec_timer_if.sv
// Control and display bundle of the MM:SS timer: start/load/tick controls in,
// four BCD digits and status pulses out.
interface bcd_min_sec_timer_if;
  logic       TICK;
  logic       START;
  logic       MODE;
  logic       LOAD;
  logic [7:0] LOAD_MIN;
  logic [7:0] LOAD_SEC;
  logic [3:0] HEX3;
  logic [3:0] HEX2;
  logic [3:0] HEX1;
  logic [3:0] HEX0;
  logic       RUNNING;
  logic       DONE;
  logic       ERR;

  modport master (
    output TICK, START, MODE, LOAD, LOAD_MIN, LOAD_SEC,
    input  HEX3, HEX2, HEX1, HEX0, RUNNING, DONE, ERR
  );

  modport slave (
    input  TICK, START, MODE, LOAD, LOAD_MIN, LOAD_SEC,
    output HEX3, HEX2, HEX1, HEX0, RUNNING, DONE, ERR
  );
endinterface

// File: rtl/bcd_min_sec_timer.sv
// 4-digit BCD MM:SS up/down timer with validated preset load, start/pause/resume
// control, configurable minute ceiling, wrap-or-stop and optional internal tick divider.
module bcd_min_sec_timer #(
  parameter int unsigned MAX_MIN  = 59,
  parameter int unsigned WRAP     = 0,
  parameter int unsigned TICK_DIV = 0
) (
  input logic                CLOCK,
  input logic                RST,
  bcd_min_sec_timer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, EXPIRED} state_t;

  localparam logic [3:0]  MAX_T   = 4'(MAX_MIN / 10);
  localparam logic [3:0]  MAX_O   = 4'(MAX_MIN % 10);
  localparam logic [15:0] TOP_VAL = {MAX_T, MAX_O, 4'd5, 4'd9};
  localparam int unsigned DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = (TICK_DIV > 0) ? DIV_W'(TICK_DIV - 1) : DIV_W'(0);

  state_t           state;
  logic [3:0]       m1, m0, s1, s0;
  logic [DIV_W-1:0] div;
  logic             running, done, err;

  logic             tick;
  logic             load_ok;
  logic             at_term;
  logic             hits_term;
  logic [15:0]      term_val;
  logic [15:0]      wrap_val;
  logic [15:0]      next_val;
  logic [3:0]       n_m1, n_m0, n_s1, n_s0;

  // BCD ordering on valid digits matches numeric ordering, so the ceiling is a plain compare.
  always_comb begin
    load_ok = (bus.LOAD_MIN[7:4] <= 4'd9) && (bus.LOAD_MIN[3:0] <= 4'd9) &&
              (bus.LOAD_SEC[7:4] <= 4'd5) && (bus.LOAD_SEC[3:0] <= 4'd9) &&
              (bus.LOAD_MIN <= {MAX_T, MAX_O});
  end

  always_comb begin
    if (TICK_DIV == 0) tick = (state == RUN) && bus.TICK;
    else               tick = (state == RUN) && (div == DIV_LAST);
  end

  always_comb begin
    term_val = bus.MODE ? 16'h0000 : TOP_VAL;
    wrap_val = bus.MODE ? TOP_VAL  : 16'h0000;
    at_term  = ({m1, m0, s1, s0} == term_val);
  end

  // Full carry/borrow ripple in one step so the display never shows an intermediate value.
  always_comb begin
    n_m1 = m1;
    n_m0 = m0;
    n_s1 = s1;
    n_s0 = s0;
    if (!bus.MODE) begin
      if (s0 != 4'd9) n_s0 = s0 + 4'd1;
      else begin
        n_s0 = 4'd0;
        if (s1 != 4'd5) n_s1 = s1 + 4'd1;
        else begin
          n_s1 = 4'd0;
          if (m0 != 4'd9) n_m0 = m0 + 4'd1;
          else begin
            n_m0 = 4'd0;
            n_m1 = m1 + 4'd1;
          end
        end
      end
    end else begin
      if (s0 != 4'd0) n_s0 = s0 - 4'd1;
      else begin
        n_s0 = 4'd9;
        if (s1 != 4'd0) n_s1 = s1 - 4'd1;
        else begin
          n_s1 = 4'd5;
          if (m0 != 4'd0) n_m0 = m0 - 4'd1;
          else begin
            n_m0 = 4'd9;
            n_m1 = m1 - 4'd1;
          end
        end
      end
    end
    next_val  = {n_m1, n_m0, n_s1, n_s0};
    hits_term = (next_val == term_val);
  end

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      state   <= IDLE;
      {m1, m0, s1, s0} <= '0;
      div     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (bus.LOAD) begin
        state   <= IDLE;
        running <= 1'b0;
        div     <= '0;
        if (load_ok) {m1, m0, s1, s0} <= {bus.LOAD_MIN, bus.LOAD_SEC};
        else         err <= 1'b1;
      end else if (bus.START) begin
        // A tick coinciding with pause is dropped and the divider phase is frozen.
        case (state)
          IDLE:    begin state <= RUN;  running <= 1'b1; end
          RUN:     begin state <= HOLD; running <= 1'b0; end
          HOLD:    begin state <= RUN;  running <= 1'b1; end
          default: state <= state;
        endcase
      end else begin
        if (state == RUN) begin
          if (TICK_DIV > 0) div <= (div == DIV_LAST) ? '0 : div + 1'b1;
        end else if (state != HOLD) begin
          div <= '0;
        end
        if (tick) begin
          if (at_term) begin
            done <= 1'b1;
            if (WRAP != 0) begin
              {m1, m0, s1, s0} <= wrap_val;
            end else begin
              state   <= EXPIRED;
              running <= 1'b0;
            end
          end else begin
            {m1, m0, s1, s0} <= next_val;
            if ((WRAP == 0) && hits_term) begin
              done    <= 1'b1;
              state   <= EXPIRED;
              running <= 1'b0;
            end
          end
        end
      end
    end
  end

  assign bus.HEX3    = m1;
  assign bus.HEX2    = m0;
  assign bus.HEX1    = s1;
  assign bus.HEX0    = s0;
  assign bus.RUNNING = running;
  assign bus.DONE    = done;
  assign bus.ERR     = err;

endmodule

// File: tb/tb_bcd_min_sec_timer.sv
// Bench for bcd_min_sec_timer: four parameter variants, per-cycle vectors with
// expected outputs queued at drive time and popped after the clock edge.
module tb_bcd_min_sec_timer;

  typedef struct packed {
    logic       load;
    logic       start;
    logic       tick;
    logic       mode;
    logic [7:0] lm;
    logic [7:0] ls;
    logic       rst;
  } stim_t;

  typedef struct packed {
    stim_t       s;
    logic [18:0] e;
  } vec_t;

  typedef struct {
    string       name;
    logic [18:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_min_sec_timer_if if0();
  bcd_min_sec_timer_if if1();
  bcd_min_sec_timer_if if2();
  bcd_min_sec_timer_if if3();

  bcd_min_sec_timer #(.MAX_MIN(59), .WRAP(0), .TICK_DIV(0)) u0 (.CLOCK(clk), .RST(rst), .bus(if0));
  bcd_min_sec_timer #(.MAX_MIN(59), .WRAP(1), .TICK_DIV(0)) u1 (.CLOCK(clk), .RST(rst), .bus(if1));
  bcd_min_sec_timer #(.MAX_MIN(59), .WRAP(0), .TICK_DIV(4)) u2 (.CLOCK(clk), .RST(rst), .bus(if2));
  bcd_min_sec_timer #(.MAX_MIN(30), .WRAP(0), .TICK_DIV(0)) u3 (.CLOCK(clk), .RST(rst), .bus(if3));

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  vec_t        plan[$];
  exp_t        sb[$];

  function automatic stim_t S(input logic load, input logic start, input logic tick,
                              input logic mode, input logic [7:0] lm, input logic [7:0] ls);
    return {load, start, tick, mode, lm, ls, 1'b0};
  endfunction

  function automatic logic [18:0] X(input logic [15:0] hex, input logic run,
                                    input logic done, input logic err);
    return {hex, run, done, err};
  endfunction

  task automatic add(input stim_t s, input logic [18:0] e);
    plan.push_back({s, e});
  endtask

  task automatic drive(input int d, input stim_t s);
    rst = s.rst;
    case (d)
      0: begin if0.LOAD = s.load; if0.START = s.start; if0.TICK = s.tick; if0.MODE = s.mode;
               if0.LOAD_MIN = s.lm; if0.LOAD_SEC = s.ls; end
      1: begin if1.LOAD = s.load; if1.START = s.start; if1.TICK = s.tick; if1.MODE = s.mode;
               if1.LOAD_MIN = s.lm; if1.LOAD_SEC = s.ls; end
      2: begin if2.LOAD = s.load; if2.START = s.start; if2.TICK = s.tick; if2.MODE = s.mode;
               if2.LOAD_MIN = s.lm; if2.LOAD_SEC = s.ls; end
      default: begin if3.LOAD = s.load; if3.START = s.start; if3.TICK = s.tick; if3.MODE = s.mode;
               if3.LOAD_MIN = s.lm; if3.LOAD_SEC = s.ls; end
    endcase
  endtask

  function automatic logic [18:0] obs(input int d);
    case (d)
      0: return {if0.HEX3, if0.HEX2, if0.HEX1, if0.HEX0, if0.RUNNING, if0.DONE, if0.ERR};
      1: return {if1.HEX3, if1.HEX2, if1.HEX1, if1.HEX0, if1.RUNNING, if1.DONE, if1.ERR};
      2: return {if2.HEX3, if2.HEX2, if2.HEX1, if2.HEX0, if2.RUNNING, if2.DONE, if2.ERR};
      default: return {if3.HEX3, if3.HEX2, if3.HEX1, if3.HEX0, if3.RUNNING, if3.DONE, if3.ERR};
    endcase
  endfunction

  task automatic test_reset();
    exp_t        e;
    logic [18:0] o;
    drive(0, S(1, 1, 1, 1, 8'h12, 8'h34));
    drive(1, S(0, 1, 1, 0, 8'h00, 8'h00));
    rst = 1'b1;
    for (int d = 0; d < 4; d++) sb.push_back('{$sformatf("reset_u%0d", d), X(16'h0000, 0, 0, 0)});
    repeat (2) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      e = sb.pop_front();
      o = obs(d);
      vectors++;
      if (o !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h r%b d%b e%b, want %h r%b d%b e%b", e.name,
                 o[18:3], o[2], o[1], o[0], e.val[18:3], e.val[2], e.val[1], e.val[0]);
      end
    end
    for (int d = 0; d < 4; d++) drive(d, S(0, 0, 0, 0, 8'h00, 8'h00));
    rst = 1'b0;
  endtask

  task automatic test_countdown();
    exp_t        e;
    logic [18:0] o;
    plan.delete();
    add(S(1, 0, 0, 0, 8'h00, 8'h05), X(16'h0005, 0, 0, 0));
    add(S(0, 1, 0, 1, 8'h00, 8'h00), X(16'h0005, 1, 0, 0));
    for (int k = 4; k >= 0; k--)
      add(S(0, 0, 1, 1, 8'h00, 8'h00), X({12'h000, 4'(k)}, k != 0, k == 0, 0));
    repeat (3) add(S(0, 0, 1, 1, 8'h00, 8'h00), X(16'h0000, 0, 0, 0));
    add(S(0, 1, 1, 1, 8'h00, 8'h00), X(16'h0000, 0, 0, 0));
    foreach (plan[i]) begin
      drive(0, plan[i].s);
      sb.push_back('{$sformatf("countdown[%0d]", i), plan[i].e});
      @(negedge clk);
      e = sb.pop_front();
      o = obs(0);
      vectors++;
      if (o !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h r%b d%b e%b, want %h r%b d%b e%b", e.name,
                 o[18:3], o[2], o[1], o[0], e.val[18:3], e.val[2], e.val[1], e.val[0]);
      end
    end
    drive(0, S(0, 0, 0, 0, 8'h00, 8'h00));
  endtask

  task automatic test_carry_and_load();
    exp_t        e;
    logic [18:0] o;
    plan.delete();
    add(S(1, 0, 0, 0, 8'h09, 8'h59), X(16'h0959, 0, 0, 0));
    add(S(0, 1, 0, 0, 8'h00, 8'h00), X(16'h0959, 1, 0, 0));
    add(S(0, 0, 1, 0, 8'h00, 8'h00), X(16'h1000, 1, 0, 0));
    add(S(1, 0, 0, 0, 8'h0A, 8'h00), X(16'h1000, 0, 0, 1));
    add(S(1, 0, 0, 0, 8'h00, 8'h60), X(16'h1000, 0, 0, 1));
    add(S(1, 0, 0, 0, 8'h00, 8'h0A), X(16'h1000, 0, 0, 1));
    add(S(1, 0, 0, 0, 8'h60, 8'h00), X(16'h1000, 0, 0, 1));
    add(S(1, 0, 0, 0, 8'h59, 8'h59), X(16'h5959, 0, 0, 0));
    add(S(0, 1, 0, 0, 8'h00, 8'h00), X(16'h5959, 1, 0, 0));
    add(S(0, 0, 1, 0, 8'h00, 8'h00), X(16'h5959, 0, 1, 0));
    foreach (plan[i]) begin
      drive(0, plan[i].s);
      sb.push_back('{$sformatf("carry_load[%0d]", i), plan[i].e});
      @(negedge clk);
      e = sb.pop_front();
      o = obs(0);
      vectors++;
      if (o !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h r%b d%b e%b, want %h r%b d%b e%b", e.name,
                 o[18:3], o[2], o[1], o[0], e.val[18:3], e.val[2], e.val[1], e.val[0]);
      end
    end
    drive(0, S(0, 0, 0, 0, 8'h00, 8'h00));
  endtask

  task automatic test_wrap();
    exp_t        e;
    logic [18:0] o;
    plan.delete();
    add(S(1, 0, 0, 0, 8'h59, 8'h59), X(16'h5959, 0, 0, 0));
    add(S(0, 1, 0, 0, 8'h00, 8'h00), X(16'h5959, 1, 0, 0));
    add(S(0, 0, 1, 0, 8'h00, 8'h00), X(16'h0000, 1, 1, 0));
    add(S(0, 0, 1, 0, 8'h00, 8'h00), X(16'h0001, 1, 0, 0));
    add(S(1, 0, 0, 1, 8'h00, 8'h00), X(16'h0000, 0, 0, 0));
    add(S(0, 1, 0, 1, 8'h00, 8'h00), X(16'h0000, 1, 0, 0));
    add(S(0, 0, 1, 1, 8'h00, 8'h00), X(16'h5959, 1, 1, 0));
    add(S(0, 0, 1, 1, 8'h00, 8'h00), X(16'h5958, 1, 0, 0));
    add(S(0, 1, 0, 1, 8'h00, 8'h00), X(16'h5958, 0, 0, 0));
    foreach (plan[i]) begin
      drive(1, plan[i].s);
      sb.push_back('{$sformatf("wrap[%0d]", i), plan[i].e});
      @(negedge clk);
      e = sb.pop_front();
      o = obs(1);
      vectors++;
      if (o !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h r%b d%b e%b, want %h r%b d%b e%b", e.name,
                 o[18:3], o[2], o[1], o[0], e.val[18:3], e.val[2], e.val[1], e.val[0]);
      end
    end
    drive(1, S(0, 0, 0, 0, 8'h00, 8'h00));
  endtask

  // External TICK is held high throughout: with the internal divider it must have no effect.
  task automatic test_divider();
    exp_t        e;
    logic [18:0] o;
    plan.delete();
    add(S(1, 0, 1, 0, 8'h00, 8'h00), X(16'h0000, 0, 0, 0));
    add(S(0, 1, 1, 0, 8'h00, 8'h00), X(16'h0000, 1, 0, 0));
    for (int c = 1; c <= 6; c++)
      add(S(0, 0, 1, 0, 8'h00, 8'h00), X((c >= 4) ? 16'h0001 : 16'h0000, 1, 0, 0));
    add(S(0, 1, 1, 0, 8'h00, 8'h00), X(16'h0001, 0, 0, 0));
    repeat (10) add(S(0, 0, 1, 0, 8'h00, 8'h00), X(16'h0001, 0, 0, 0));
    add(S(0, 1, 1, 0, 8'h00, 8'h00), X(16'h0001, 1, 0, 0));
    add(S(0, 0, 1, 0, 8'h00, 8'h00), X(16'h0001, 1, 0, 0));
    add(S(0, 0, 1, 0, 8'h00, 8'h00), X(16'h0002, 1, 0, 0));
    add(S(0, 0, 1, 0, 8'h00, 8'h00), X(16'h0002, 1, 0, 0));
    add(S(0, 0, 1, 0, 8'h00, 8'h00), X(16'h0002, 1, 0, 0));
    foreach (plan[i]) begin
      drive(2, plan[i].s);
      sb.push_back('{$sformatf("divider[%0d]", i), plan[i].e});
      @(negedge clk);
      e = sb.pop_front();
      o = obs(2);
      vectors++;
      if (o !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h r%b d%b e%b, want %h r%b d%b e%b", e.name,
                 o[18:3], o[2], o[1], o[0], e.val[18:3], e.val[2], e.val[1], e.val[0]);
      end
    end
    drive(2, S(0, 0, 0, 0, 8'h00, 8'h00));
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [18:0] o;
    stim_t       s;
    plan.delete();
    add(S(1, 0, 0, 1, 8'h03, 8'h20), X(16'h0320, 0, 0, 0));
    add(S(0, 1, 0, 1, 8'h00, 8'h00), X(16'h0320, 1, 0, 0));
    add(S(0, 1, 1, 1, 8'h00, 8'h00), X(16'h0320, 0, 0, 0));
    add(S(0, 0, 1, 1, 8'h00, 8'h00), X(16'h0320, 0, 0, 0));
    add(S(0, 1, 0, 1, 8'h00, 8'h00), X(16'h0320, 1, 0, 0));
    add(S(0, 0, 1, 1, 8'h00, 8'h00), X(16'h0319, 1, 0, 0));
    s = S(1, 1, 1, 1, 8'h12, 8'h34);
    s.rst = 1'b1;
    add(s, X(16'h0000, 0, 0, 0));
    add(S(0, 0, 1, 1, 8'h00, 8'h00), X(16'h0000, 0, 0, 0));
    add(S(0, 1, 0, 1, 8'h00, 8'h00), X(16'h0000, 1, 0, 0));
    add(S(0, 0, 1, 1, 8'h00, 8'h00), X(16'h0000, 0, 1, 0));
    add(S(0, 1, 1, 1, 8'h00, 8'h00), X(16'h0000, 0, 0, 0));
    foreach (plan[i]) begin
      drive(0, plan[i].s);
      sb.push_back('{$sformatf("start_tick[%0d]", i), plan[i].e});
      @(negedge clk);
      e = sb.pop_front();
      o = obs(0);
      vectors++;
      if (o !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h r%b d%b e%b, want %h r%b d%b e%b", e.name,
                 o[18:3], o[2], o[1], o[0], e.val[18:3], e.val[2], e.val[1], e.val[0]);
      end
    end
    drive(0, S(0, 0, 0, 0, 8'h00, 8'h00));
  endtask

  task automatic test_ceiling();
    exp_t        e;
    logic [18:0] o;
    plan.delete();
    add(S(1, 0, 0, 0, 8'h31, 8'h00), X(16'h0000, 0, 0, 1));
    add(S(1, 0, 0, 0, 8'h29, 8'h59), X(16'h2959, 0, 0, 0));
    add(S(0, 1, 0, 0, 8'h00, 8'h00), X(16'h2959, 1, 0, 0));
    add(S(0, 0, 1, 0, 8'h00, 8'h00), X(16'h3000, 1, 0, 0));
    add(S(0, 0, 1, 0, 8'h00, 8'h00), X(16'h3001, 1, 0, 0));
    add(S(1, 0, 0, 0, 8'h30, 8'h59), X(16'h3059, 0, 0, 0));
    add(S(0, 1, 0, 0, 8'h00, 8'h00), X(16'h3059, 1, 0, 0));
    add(S(0, 0, 1, 0, 8'h00, 8'h00), X(16'h3059, 0, 1, 0));
    add(S(0, 0, 1, 0, 8'h00, 8'h00), X(16'h3059, 0, 0, 0));
    add(S(1, 0, 0, 1, 8'h30, 8'h59), X(16'h3059, 0, 0, 0));
    add(S(0, 1, 0, 1, 8'h00, 8'h00), X(16'h3059, 1, 0, 0));
    add(S(0, 0, 1, 1, 8'h00, 8'h00), X(16'h3058, 1, 0, 0));
    foreach (plan[i]) begin
      drive(3, plan[i].s);
      sb.push_back('{$sformatf("ceiling[%0d]", i), plan[i].e});
      @(negedge clk);
      e = sb.pop_front();
      o = obs(3);
      vectors++;
      if (o !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h r%b d%b e%b, want %h r%b d%b e%b", e.name,
                 o[18:3], o[2], o[1], o[0], e.val[18:3], e.val[2], e.val[1], e.val[0]);
      end
    end
    drive(3, S(0, 0, 0, 0, 8'h00, 8'h00));
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 4; d++) drive(d, S(0, 0, 0, 0, 8'h00, 8'h00));
    rst = 1'b1;
    test_reset();
    test_countdown();
    test_carry_and_load();
    test_wrap();
    test_divider();
    test_back_to_back();
    test_ceiling();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
